// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised SPI master, CPOL/CPHA modes, MSB/LSB order, divided SCLK
// IDLE -> SETUP -> TRANSFER -> HOLD; all outputs registered.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_WIDTH  = 2,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  slaveSelect,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [EW-1:0]         r_edge;
  logic                  r_cpol, r_cpha, r_lsb;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rxd;
  logic                  r_sclk, r_mosi, r_busy, r_done, r_err;
  logic [NUM_SLAVES-1:0] r_cs;

  logic w_sel_ok, w_tick, w_req, w_accept, w_reject, w_lead, w_last;
  logic w_sclk_edge, w_sample, w_shift, w_finish;

  always_comb begin
    w_state_next = r_state;
    w_sel_ok     = {1'b0, slaveSelect} < (SEL_WIDTH + 1)'(NUM_SLAVES);
    w_tick       = (r_cnt == CNT_LAST);
    // the done cycle is still IDLE, but start is ignored there
    w_req        = (r_state == IDLE) && start && !r_done;
    w_accept     = w_req && w_sel_ok;
    w_reject     = w_req && !w_sel_ok;
    w_lead       = ~r_edge[0];
    w_last       = (r_edge == EDGE_LAST);
    w_sclk_edge  = (r_state == TRANSFER) && w_tick;
    w_sample     = w_sclk_edge && (r_cpha ? !w_lead : w_lead);
    w_shift      = w_sclk_edge && (r_cpha ? (w_lead && (r_edge != '0)) : (!w_lead && !w_last));
    w_finish     = (r_state == HOLD) && w_tick;
    case (r_state)
      IDLE:     if (w_accept) w_state_next = SETUP;
      SETUP:    if (w_tick) w_state_next = TRANSFER;
      TRANSFER: if (w_tick && w_last) w_state_next = HOLD;
      HOLD:     if (w_tick) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_edge <= '0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
      r_tx   <= '0;
      r_rx   <= '0;
      r_rxd  <= '0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_cs   <= '1;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_reject;
      if (r_state == IDLE || w_tick) r_cnt <= '0;
      else                           r_cnt <= r_cnt + CW'(1);

      if (w_accept) begin
        r_cpol <= cpol;
        r_cpha <= cpha;
        r_lsb  <= lsb_first;
        r_tx   <= masterDataToSend;
        r_mosi <= lsb_first ? masterDataToSend[0] : masterDataToSend[DATA_WIDTH-1];
        r_sclk <= cpol;
        r_busy <= 1'b1;
        r_edge <= '0;
        for (int i = 0; i < NUM_SLAVES; i++) r_cs[i] <= (slaveSelect != SEL_WIDTH'(i));
      end

      if (w_sclk_edge) begin
        r_sclk <= ~r_sclk;
        r_edge <= r_edge + EW'(1);
      end

      if (w_sample) begin
        if (r_lsb) r_rx <= {MISO, r_rx[DATA_WIDTH-1:1]};
        else       r_rx <= {r_rx[DATA_WIDTH-2:0], MISO};
      end

      // MOSI is registered, so it takes the bit that becomes current after the shift
      if (w_shift) begin
        if (r_lsb) begin
          r_tx   <= r_tx >> 1;
          r_mosi <= r_tx[1];
        end else begin
          r_tx   <= r_tx << 1;
          r_mosi <= r_tx[DATA_WIDTH-2];
        end
      end

      if (w_finish) begin
        r_cs   <= '1;
        r_rxd  <= r_rx;
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_sclk <= r_cpol;
      end
    end
  end

  assign masterDataReceived = r_rxd;
  assign busy               = r_busy;
  assign done               = r_done;
  assign err                = r_err;
  assign SCLK               = r_sclk;
  assign CS                 = r_cs;
  assign MOSI               = r_mosi;

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master. Supports configurable word width and slave count, all four CPOL/CPHA modes, and MSB- or LSB-first ordering. SCLK comes from a programmable divider of the system clock. A start/busy/done handshake connects it to the controlling micro-controller logic. It sits between that logic and up to NUM_SLAVES SPI slaves on shared SCLK/MOSI/MISO with one active-low chip select per slave.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
NUM_SLAVES, 3, number of chip-select lines (>=1)
SEL_WIDTH, 2, width of slaveSelect (2**SEL_WIDTH >= NUM_SLAVES)
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  transfer request, sampled only in IDLE
slaveSelect  in  SEL_WIDTH  target slave index
cpol  in  1  SCLK idle level, latched at accept
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched at accept
lsb_first  in  1  1: LSB first, 0: MSB first; latched at accept
masterDataToSend  in  DATA_WIDTH  word to transmit, latched at accept
masterDataReceived  out  DATA_WIDTH  last complete received word
busy  out  1  high from accept until done
done  out  1  one-cycle pulse, transfer complete
err  out  1  one-cycle pulse, start rejected (slaveSelect >= NUM_SLAVES)
SCLK  out  1  serial clock
CS  out  NUM_SLAVES  active-low chip selects, bit i selects slave i
MOSI  out  1  serial data out
MISO  in  1  serial data in

Behaviour:
- Reset values (async, reset low): state=IDLE, CS all ones, SCLK=0, MOSI=0, masterDataReceived=0, busy=0, done=0, err=0, latched cpol=0.
- States: IDLE, SETUP, TRANSFER, HOLD.
- IDLE + start + valid slaveSelect → SETUP next cycle:
  - latch cpol, cpha, lsb_first and masterDataToSend into the shift register;
  - drive CS[slaveSelect]=0, others 1;
  - drive the first data bit on MOSI; set busy=1.
- IDLE + start + slaveSelect >= NUM_SLAVES → err=1 for one cycle. State, CS and busy are unchanged.
- SCLK idles at the latched cpol in IDLE, SETUP and HOLD. In IDLE after reset it is 0; afterwards it holds the last latched cpol.
- SETUP: lasts CLK_DIV cycles, then → TRANSFER.
- TRANSFER: SCLK toggles every CLK_DIV cycles, giving 2*DATA_WIDTH edges. Odd edges are leading, even edges are trailing.
  - cpha=0: sample MISO on leading edges; shift MOSI on trailing edges, except the final trailing edge.
  - cpha=1: shift MOSI on leading edges, except the first; sample MISO on trailing edges.
  - Sampling and shifting happen in the clk cycle the SCLK edge is driven.
- Bit order:
  - lsb_first=1: transmit bit 0 first; received bits enter at the MSB and shift right.
  - lsb_first=0: transmit bit DATA_WIDTH-1 first; received bits enter at the LSB and shift left.
- After the last edge → HOLD for CLK_DIV cycles, SCLK at idle level, CS still asserted. Then → IDLE:
  - CS all ones;
  - masterDataReceived loads the assembled word (it is updated only here, never with partial data);
  - done=1 for one cycle; busy=0.
- done is registered high exactly (2*DATA_WIDTH+2)*CLK_DIV cycles after the accepting clk edge.
- start while busy, or in the done cycle, is ignored with no err. The next transfer can be accepted the cycle after done.
- Config and data inputs changing mid-transfer have no effect.
- Reset mid-transfer: immediate abort to reset values. No done pulse. The partial word is discarded.
- MOSI holds its last value in IDLE.

Test Plan:
1. DATA_WIDTH=8, CLK_DIV=2, mode 0, MSB-first, slaveSelect=0, send 0xA5, MISO looped to MOSI → CS=3'b110 during transfer; 8 rising SCLK edges; done at cycle 36; masterDataReceived=0xA5; busy low after.
2. Mode 3 (cpol=1, cpha=1), slave model returning 0x3C MSB-first, send 0xC3, slaveSelect=2 → SCLK idles high; slave captures 0xC3; masterDataReceived=0x3C; CS=3'b011 during transfer.
3. Modes 1 and 2, lsb_first=1, loopback, send 0x01 then 0x80 → received words 0x01 and 0x80; MOSI carries bit 0 first on the scope trace.
4. slaveSelect=3 with NUM_SLAVES=3, start pulsed → err one cycle; CS stays 3'b111; busy stays 0; no SCLK edges.
5. Assert reset low at cycle 10 of a 0xFF transfer → CS=3'b111, SCLK=0, busy=0, no done, masterDataReceived=0; a new transfer of 0x5A after release completes correctly.
6. start held high through a transfer, new masterDataToSend mid-transfer → first word unaffected; second transfer accepted the cycle after done; DATA_WIDTH=16, CLK_DIV=1 variant: done at cycle 34.
